instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Initiator side of the instruction-memory port: owns the PC, drives ins_memory.address_in and captures instruction_out.
//  Buffers fetched words in a 2-entry queue and hands {pc, instr} to decode over a valid/ready handshake.
//  Handles control-flow redirects from execute by flushing queued and in-flight fetches.
// PARAMETERS
//  ADDR_W    8             word-address width of ins_memory (depth 2**ADDR_W words)
//  RESET_PC  32'h0000_0000 byte PC loaded at reset
//  DEPTH     2             fetch-queue entries (fixed at 2; any other value is illegal)
// PORTS
//  clk            in   1       clock, all state updates on posedge
//  rst_n          in   1       asynchronous active-low reset
//  fetch_en_i     in   1       1 = new fetches may issue; 0 = hold PC, drain queue
//  mem_addr_o     out  ADDR_W  word address to ins_memory.address_in (= fetch_pc[ADDR_W+1:2])
//  mem_instr_i    in   32      ins_memory.instruction_out, valid 1 cycle after address
//  if_valid_o     out  1       decode output holds a valid instruction
//  if_ready_i     in   1       decode accepts; transfer when valid & ready
//  if_instr_o     out  32      instruction; 32'h0000_0013 (NOP) when if_valid_o=0
//  if_pc_o        out  32      byte PC of if_instr_o; 0 when if_valid_o=0
//  redirect_i     in   1       branch/jump taken, single-cycle pulse
//  redirect_pc_i  in   32      new byte PC, sampled when redirect_i=1
//  fault_o        out  1       misaligned-redirect fault (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async assert, sync release): fetch_pc=RESET_PC, mem_addr_o=RESET_PC[ADDR_W+1:2], queue empty,
//    inflight=0, if_valid_o=0, fault_o=0, state=BOOT.
//  FSM: BOOT -> RUN (1 cycle after release); RUN -> FLUSH on redirect_i; FLUSH -> RUN next cycle;
//    RUN/FLUSH -> FAULT (ALIGN_CHECK only); FAULT -> FLUSH on an aligned redirect.
//  Issue: in RUN with fetch_en_i=1 and (count + inflight - pop) < DEPTH, the current fetch_pc is the request;
//    inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4.
//    The cycle after, mem_instr_i is written to the queue tail with inflight_pc.
//  Memory latency is exactly 1 cycle; mem_addr_o always equals fetch_pc bits (no separate enable to memory).
//  Queue: head drives if_*_o; pop on valid&ready; push and pop in the same cycle are allowed at any count.
//  Throughput: 1 instr/cycle sustained while if_ready_i=1.
//    Reset-release to first if_valid_o: 3 cycles.
//  Redirect (highest priority, any state): queue cleared, in-flight response discarded (inflight<=0),
//    fetch_pc<=redirect_pc_i, state=FLUSH; if_valid_o=0 from the next cycle; no issue during FLUSH.
//    First redirected instr valid 3 cycles after the redirect cycle.
//    A concurrent pop in the redirect cycle still completes.
//  fetch_en_i=0: no new issue; an in-flight response is still captured; queued entries still drain.
//  Wrap: fetch_pc wraps mod 2**32; mem_addr_o wraps mod 2**ADDR_W (PCs >= 4*2**ADDR_W alias).
//  Reset mid-operation: everything returns to reset values immediately; any pending response is dropped.
// CONFIGURATION
//  `FETCH_ALIGN_CHECK_EN defined: redirect_pc_i[1:0]!=0 -> state=FAULT, fault_o=1 (sticky), queue flushed, no issue;
//    cleared only by reset or a redirect with [1:0]==0.
//  Not defined: redirect_pc_i[1:0] forced to 0 and fault_o tied 0; the FAULT state is not built.
// STRUCTURE
//  riscv_fetch_pkg: fetch_state_t {BOOT,RUN,FLUSH,FAULT}, fetch_entry_t {pc[31:0], instr[31:0]},
//    XLEN=32, NOP_INSTR=32'h0000_0013.
//  Sub-module fetch_queue: 2-entry FIFO of fetch_entry_t with push/pop/flush, count, full and empty.
//  The top level holds the FSM, PC, inflight tracking, issue logic and alignment check.
// TESTING (bench drives the real ins_memory)
//  Reset, RESET_PC=0, ready=1 -> addr 0,1,2..; if_pc_o 0,4,8.. valid from cycle 3, one per cycle, instr matches mem[i].
//  Hold ready=0 for 5 cycles after first valid -> exactly 2 queued, PC stops at 0x0C; on release pcs 0,4,8 are contiguous.
//  Redirect to 0x20 while queue holds pc 4,8 -> valid drops next cycle; next accepted pc=0x20 after 3 cycles; 4 and 8 are never seen.
//  Redirect with pc=0x3FC then run -> pcs 0x3FC,0x400 with mem_addr_o 0xFF then 0x00 (wrap).
//  fetch_en_i=0 mid-stream -> queue drains, no new addr; on re-enable fetch resumes at next sequential pc.
//  ALIGN_CHECK_EN: redirect 0x22 -> fault_o=1, valid=0; then redirect 0x40 -> fault_o=0, pc 0x40 valid after 3 cycles.

Source files
------------

// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package riscv_fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched {pc, instr} pairs. Push and pop may coincide at
// any occupancy; flush empties the queue and takes priority over push/pop.
module fetch_queue
    import riscv_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head_entry,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    fetch_entry_t entries_r [2];
    logic         rd_ptr_r;
    logic [1:0]   count_r;
    logic         wr_ptr_s;
    logic         pop_ok_s;
    logic         push_ok_s;

    assign full       = (count_r == 2'd2);
    assign empty      = (count_r == 2'd0);
    assign count      = count_r;
    assign head_entry = entries_r[rd_ptr_r];

    // When full, the tail slot coincides with the head being popped.
    assign wr_ptr_s  = rd_ptr_r ^ count_r[0];
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);

    // Storage, read pointer and occupancy update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                entries_r[i] <= '0;
            end
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else if (flush) begin
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_ok_s) begin
                entries_r[wr_ptr_s] <= push_entry;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the instruction memory address,
// captures the 1-cycle-latency response into a 2-entry queue and presents the
// queue head to decode over valid/ready. Redirects flush everything in flight.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned-redirect fault).
module instr_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter int              ADDR_W   = 8,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2   // queue is built for exactly 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [XLEN-1:0]   mem_instr_i,
    output logic              if_valid_o,
    input  logic              if_ready_i,
    output logic [XLEN-1:0]   if_instr_o,
    output logic [XLEN-1:0]   if_pc_o,
    input  logic              redirect_i,
    input  logic [XLEN-1:0]   redirect_pc_i,
    output logic              fault_o
);

    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    fetch_state_t    state_r;
    fetch_state_t    state_nxt_s;
    logic [XLEN-1:0] fetch_pc_r;
    logic            inflight_r;
    logic [XLEN-1:0] inflight_pc_r;
    logic [XLEN-1:0] redirect_pc_s;
    logic [2:0]      occ_s;
    logic            issue_s;
    logic            pop_s;
    logic            push_s;
    fetch_entry_t    push_entry_s;
    fetch_entry_t    head_entry_s;
    logic [1:0]      q_count_s;
    logic            q_full_s;
    logic            q_empty_s;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_s;
    logic fault_r;

    assign misalign_s    = (redirect_pc_i[1:0] != 2'b00);
    assign redirect_pc_s = redirect_pc_i;
    assign fault_o       = fault_r;

    // Sticky misaligned-redirect flag; only a redirect (or reset) changes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_r <= 1'b0;
        end else if (redirect_i) begin
            fault_r <= misalign_s;
        end else begin
            fault_r <= fault_r;
        end
    end
`else
    logic unused_pc_lsb_s;

    // Redirect targets are forced word-aligned; the low bits are ignored.
    assign unused_pc_lsb_s = ^redirect_pc_i[1:0];
    assign redirect_pc_s   = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign fault_o         = 1'b0;
`endif

    assign mem_addr_o = fetch_pc_r[ADDR_W+1:2];

    assign if_valid_o = !q_empty_s;
    assign if_instr_o = if_valid_o ? head_entry_s.instr : NOP_INSTR;
    assign if_pc_o    = if_valid_o ? head_entry_s.pc : 32'h0000_0000;

    assign pop_s = if_valid_o && if_ready_i;

    // Slots that will be committed once this cycle's pop leaves.
    assign occ_s   = {1'b0, q_count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
    assign issue_s = (state_r == RUN) && fetch_en_i && !redirect_i && (occ_s < DEPTH_C);

    // The response arriving this cycle belongs to last cycle's issue unless a
    // redirect is discarding it.
    assign push_s       = inflight_r && !redirect_i && (!q_full_s || pop_s);
    assign push_entry_s = '{pc: inflight_pc_r, instr: mem_instr_i};

    fetch_queue u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .flush      (redirect_i),
        .head_entry (head_entry_s),
        .count      (q_count_s),
        .full       (q_full_s),
        .empty      (q_empty_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= BOOT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: a redirect overrides every state.
    always_comb begin
        state_nxt_s = state_r;
        if (redirect_i) begin
`ifdef FETCH_ALIGN_CHECK_EN
            if (misalign_s) begin
                state_nxt_s = FAULT;
            end else begin
                state_nxt_s = FLUSH;
            end
`else
            state_nxt_s = FLUSH;
`endif
        end else begin
            case (state_r)
                BOOT:    state_nxt_s = RUN;
                RUN:     state_nxt_s = RUN;
                FLUSH:   state_nxt_s = RUN;
`ifdef FETCH_ALIGN_CHECK_EN
                FAULT:   state_nxt_s = FAULT;
`endif
                default: state_nxt_s = BOOT;
            endcase
        end
    end

    // PC advance and in-flight request tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_r    <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= 32'h0000_0000;
        end else if (redirect_i) begin
            fetch_pc_r    <= redirect_pc_s;
            inflight_r    <= 1'b0;
            inflight_pc_r <= inflight_pc_r;
        end else if (issue_s) begin
            fetch_pc_r    <= fetch_pc_r + 32'd4;
            inflight_r    <= 1'b1;
            inflight_pc_r <= fetch_pc_r;
        end else begin
            fetch_pc_r    <= fetch_pc_r;
            inflight_r    <= 1'b0;
            inflight_pc_r <= inflight_pc_r;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a 1-cycle registered instruction
// memory model. Define FETCH_ALIGN_CHECK_EN to exercise the fault feature.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic [7:0]  mem_addr;
    logic [31:0] mem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fault;

    logic [31:0] mem [0:255];
    int          checks = 0;
    int          fails  = 0;

    instr_fetch_unit #(.ADDR_W(8), .RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_en_i    (fetch_en),
        .mem_addr_o    (mem_addr),
        .mem_instr_i   (mem_rdata),
        .if_valid_o    (if_valid),
        .if_ready_i    (if_ready),
        .if_instr_o    (if_instr),
        .if_pc_o       (if_pc),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .fault_o       (fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_rdata <= mem[mem_addr];

    function automatic logic [31:0] exp_instr(input logic [31:0] pc);
        logic [31:0] w;
        w = {24'h000000, pc[9:2]};
        return 32'h1000_0000 + w * 32'h0001_0001;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; fetch_en = 1'b1; if_ready = 1'b1;
        redirect = 1'b0; redirect_pc = 32'h0;
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fetch_en = 1'b1; if_ready = 1'b1;
        redirect = 1'b0; redirect_pc = 32'h0;
        step();
        checks++;
        if (if_valid !== 1'b0 || if_instr !== 32'h0000_0013 || if_pc !== 32'h0 ||
            mem_addr !== 8'h00 || fault !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: valid=%0b instr=%h pc=%h addr=%h fault=%0b, expected 0/00000013/0/00/0",
                     if_valid, if_instr, if_pc, mem_addr, fault);
        end
        rst_n = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            step();
            checks++;
            if (if_valid !== 1'b0 || mem_addr !== 8'(c - 1)) begin
                fails++;
                $display("FAIL boot_cycle%0d: valid=%0b addr=%h, expected valid=0 addr=%h",
                         c, if_valid, mem_addr, 8'(c - 1));
            end
        end
    endtask

    task automatic test_stream();
        logic [31:0] epc;
        do_reset();
        step(); step();
        for (int k = 0; k < 8; k++) begin
            step();
            epc = 32'(4 * k);
            checks++;
            if (if_valid !== 1'b1 || if_pc !== epc || if_instr !== exp_instr(epc) ||
                mem_addr !== 8'(k + 2)) begin
                fails++;
                $display("FAIL stream_%0d: valid=%0b pc=%h instr=%h addr=%h, expected pc=%h instr=%h addr=%h",
                         k, if_valid, if_pc, if_instr, mem_addr, epc, exp_instr(epc), 8'(k + 2));
            end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (if_valid !== 1'b0 || mem_addr !== 8'h00 || if_pc !== 32'h0) begin
            fails++;
            $display("FAIL midrun_reset: valid=%0b addr=%h pc=%h, expected 0/00/0", if_valid, mem_addr, if_pc);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] epc;
        do_reset();
        step(); step(); step();
        step();
        if_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'h4 || mem_addr !== 8'h03) begin
                fails++;
                $display("FAIL hold_%0d: valid=%0b pc=%h addr=%h, expected valid=1 pc=4 addr=03",
                         k, if_valid, if_pc, mem_addr);
            end
        end
        if_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            epc = 32'(8 + 4 * k);
            checks++;
            if (if_valid !== 1'b1 || if_pc !== epc || if_instr !== exp_instr(epc)) begin
                fails++;
                $display("FAIL release_%0d: valid=%0b pc=%h instr=%h, expected pc=%h instr=%h",
                         k, if_valid, if_pc, if_instr, epc, exp_instr(epc));
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        step(); step(); step();
        step();
        if_ready = 1'b0;
        step();
        redirect = 1'b1; redirect_pc = 32'h20; if_ready = 1'b1;
        step();
        redirect = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0000_0013 ||
                mem_addr !== 8'((c == 2) ? 9 : 8)) begin
                fails++;
                $display("FAIL redirect_gap%0d: valid=%0b pc=%h instr=%h addr=%h, expected invalid addr=%h",
                         c, if_valid, if_pc, if_instr, mem_addr, 8'((c == 2) ? 9 : 8));
            end
            step();
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'(32'h20 + 4 * k) ||
                if_instr !== exp_instr(32'(32'h20 + 4 * k))) begin
                fails++;
                $display("FAIL redirect_pc%0d: valid=%0b pc=%h instr=%h, expected pc=%h",
                         k, if_valid, if_pc, if_instr, 32'(32'h20 + 4 * k));
            end
            step();
        end
    endtask

    task automatic test_wrap();
        do_reset();
        step(); step(); step();
        redirect = 1'b1; redirect_pc = 32'h3FC;
        step();
        redirect = 1'b0;
        checks++;
        if (mem_addr !== 8'hFF || if_valid !== 1'b0) begin
            fails++;
            $display("FAIL wrap_addr_ff: addr=%h valid=%0b, expected ff/0", mem_addr, if_valid);
        end
        step(); step();
        checks++;
        if (mem_addr !== 8'h00) begin
            fails++;
            $display("FAIL wrap_addr_00: addr=%h, expected 00", mem_addr);
        end
        step();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h3FC || if_instr !== exp_instr(32'h3FC)) begin
            fails++;
            $display("FAIL wrap_pc3fc: valid=%0b pc=%h instr=%h, expected pc=3fc instr=%h",
                     if_valid, if_pc, if_instr, exp_instr(32'h3FC));
        end
        step();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h400 || if_instr !== exp_instr(32'h0)) begin
            fails++;
            $display("FAIL wrap_pc400: valid=%0b pc=%h instr=%h, expected pc=400 instr=%h",
                     if_valid, if_pc, if_instr, exp_instr(32'h0));
        end
    endtask

    task automatic test_fetch_disable();
        do_reset();
        step(); step(); step();
        fetch_en = 1'b0;
        step();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h4 || mem_addr !== 8'h02) begin
            fails++;
            $display("FAIL disable_drain: valid=%0b pc=%h addr=%h, expected 1/4/02", if_valid, if_pc, mem_addr);
        end
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if (if_valid !== 1'b0 || mem_addr !== 8'h02) begin
                fails++;
                $display("FAIL disable_idle%0d: valid=%0b addr=%h, expected 0/02", c, if_valid, mem_addr);
            end
        end
        fetch_en = 1'b1;
        step();
        checks++;
        if (if_valid !== 1'b0 || mem_addr !== 8'h03) begin
            fails++;
            $display("FAIL reenable_issue: valid=%0b addr=%h, expected 0/03", if_valid, mem_addr);
        end
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'(8 + 4 * k) || if_instr !== exp_instr(32'(8 + 4 * k))) begin
                fails++;
                $display("FAIL reenable_pc%0d: valid=%0b pc=%h instr=%h, expected pc=%h",
                         k, if_valid, if_pc, if_instr, 32'(8 + 4 * k));
            end
        end
    endtask

    task automatic test_align();
        do_reset();
        step(); step(); step();
        redirect = 1'b1; redirect_pc = 32'h22;
        step();
        redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (fault !== 1'b1 || if_valid !== 1'b0) begin
                fails++;
                $display("FAIL align_fault%0d: fault=%0b valid=%0b, expected 1/0", c, fault, if_valid);
            end
            step();
        end
        redirect = 1'b1; redirect_pc = 32'h40;
        step();
        redirect = 1'b0;
        checks++;
        if (fault !== 1'b0 || if_valid !== 1'b0) begin
            fails++;
            $display("FAIL align_clear: fault=%0b valid=%0b, expected 0/0", fault, if_valid);
        end
        step(); step(); step();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_instr !== exp_instr(32'h40)) begin
            fails++;
            $display("FAIL align_resume: valid=%0b pc=%h instr=%h, expected pc=40", if_valid, if_pc, if_instr);
        end
`else
        checks++;
        if (fault !== 1'b0 || if_valid !== 1'b0) begin
            fails++;
            $display("FAIL noalign_fault: fault=%0b valid=%0b, expected 0/0", fault, if_valid);
        end
        step(); step(); step();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h20 || if_instr !== exp_instr(32'h20) || fault !== 1'b0) begin
            fails++;
            $display("FAIL noalign_pc: valid=%0b pc=%h instr=%h fault=%0b, expected pc=20 fault=0",
                     if_valid, if_pc, if_instr, fault);
        end
`endif
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0001;
        end
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_fetch_disable();
        test_align();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
